// File: rtl/bcd_rtc_param.sv
// BCD real-time clock: prescaled 1 Hz tick, HH:MM:SS counters, 12/24-hour display,
// validated time load and minute-resolution alarm. All outputs are registered.
module bcd_rtc_param #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned MODE_12H      = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_en,
    input  logic       set_valid,
    input  logic [3:0] set_hour1,
    input  logic [3:0] set_hour0,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min0,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec0,
    output logic       set_ack,
    output logic       set_err,
    input  logic       alarm_en,
    input  logic [3:0] alarm_hour1,
    input  logic [3:0] alarm_hour0,
    input  logic [3:0] alarm_min1,
    input  logic [3:0] alarm_min0,
    input  logic       alarm_clr,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] hour1,
    output logic [3:0] hour0,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       alarm_hit,
    output logic       alarm_flag
);

    localparam int unsigned PW     = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0] RST_H1  = (MODE_12H != 0) ? 4'd1 : 4'd0;
    localparam logic [3:0] RST_H0  = (MODE_12H != 0) ? 4'd2 : 4'd0;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
    logic [3:0]    disp_h1_q, disp_h1_d, disp_h0_q, disp_h0_d;
    logic          pm_q, pm_d, ack_q, ack_d, err_q, err_d;
    logic          stick_q, stick_d, dtick_q, dtick_d, hit_q, hit_d, flag_q, flag_d;
    logic          set_ok, alarm_ok, changed;

    always_comb begin
        set_ok = (set_hour1 <= 4'd2) && (set_hour0 <= 4'd9) && (set_min1 <= 4'd5)
              && (set_min0 <= 4'd9) && (set_sec1 <= 4'd5) && (set_sec0 <= 4'd9)
              && !((set_hour1 == 4'd2) && (set_hour0 > 4'd3));
        alarm_ok = (alarm_hour1 <= 4'd2) && (alarm_hour0 <= 4'd9) && (alarm_min1 <= 4'd5)
                && (alarm_min0 <= 4'd9) && !((alarm_hour1 == 4'd2) && (alarm_hour0 > 4'd3));

        pcnt_d  = pcnt_q;
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        s1_d    = s1_q;
        s0_d    = s0_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        stick_d = 1'b0;
        dtick_d = 1'b0;
        changed = 1'b0;

        // A load takes priority and swallows any tick due on the same edge.
        if (set_valid) begin
            if (set_ok) begin
                h1_d    = set_hour1;
                h0_d    = set_hour0;
                m1_d    = set_min1;
                m0_d    = set_min0;
                s1_d    = set_sec1;
                s0_d    = set_sec0;
                pcnt_d  = '0;
                ack_d   = 1'b1;
                changed = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (run_en) begin
            if (pcnt_q == PMAX) begin
                pcnt_d  = '0;
                stick_d = 1'b1;
                changed = 1'b1;
                if (s0_q != 4'd9) s0_d = s0_q + 4'd1;
                else begin
                    s0_d = 4'd0;
                    if (s1_q != 4'd5) s1_d = s1_q + 4'd1;
                    else begin
                        s1_d = 4'd0;
                        if (m0_q != 4'd9) m0_d = m0_q + 4'd1;
                        else begin
                            m0_d = 4'd0;
                            if (m1_q != 4'd5) m1_d = m1_q + 4'd1;
                            else begin
                                m1_d = 4'd0;
                                if (h1_q == 4'd2 && h0_q == 4'd3) begin
                                    h1_d    = 4'd0;
                                    h0_d    = 4'd0;
                                    dtick_d = 1'b1;
                                end else if (h0_q == 4'd9) begin
                                    h0_d = 4'd0;
                                    h1_d = h1_q + 4'd1;
                                end else begin
                                    h0_d = h0_q + 4'd1;
                                end
                            end
                        end
                    end
                end
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end

        hit_d = alarm_en && changed && alarm_ok
             && (h1_d == alarm_hour1) && (h0_d == alarm_hour0)
             && (m1_d == alarm_min1) && (m0_d == alarm_min0)
             && (s1_d == 4'd0) && (s0_d == 4'd0);
        flag_d = hit_d || (flag_q && !alarm_clr);

        pm_d      = (h1_d == 4'd2) || (h1_d == 4'd1 && h0_d >= 4'd2);
        disp_h1_d = h1_d;
        disp_h0_d = h0_d;
        if (MODE_12H != 0) begin
            if (h1_d == 4'd0 && h0_d == 4'd0) begin
                disp_h1_d = 4'd1;
                disp_h0_d = 4'd2;
            end else if (h1_d == 4'd1 && h0_d >= 4'd3) begin
                disp_h1_d = 4'd0;
                disp_h0_d = h0_d - 4'd2;
            end else if (h1_d == 4'd2 && h0_d <= 4'd1) begin
                disp_h1_d = 4'd0;
                disp_h0_d = h0_d + 4'd8;
            end else if (h1_d == 4'd2) begin
                disp_h1_d = 4'd1;
                disp_h0_d = h0_d - 4'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q    <= '0;
            h1_q      <= 4'd0;
            h0_q      <= 4'd0;
            m1_q      <= 4'd0;
            m0_q      <= 4'd0;
            s1_q      <= 4'd0;
            s0_q      <= 4'd0;
            disp_h1_q <= RST_H1;
            disp_h0_q <= RST_H0;
            pm_q      <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            stick_q   <= 1'b0;
            dtick_q   <= 1'b0;
            hit_q     <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            h1_q      <= h1_d;
            h0_q      <= h0_d;
            m1_q      <= m1_d;
            m0_q      <= m0_d;
            s1_q      <= s1_d;
            s0_q      <= s0_d;
            disp_h1_q <= disp_h1_d;
            disp_h0_q <= disp_h0_d;
            pm_q      <= pm_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            stick_q   <= stick_d;
            dtick_q   <= dtick_d;
            hit_q     <= hit_d;
            flag_q    <= flag_d;
        end
    end

    assign sec1       = s1_q;
    assign sec0       = s0_q;
    assign min1       = m1_q;
    assign min0       = m0_q;
    assign hour1      = disp_h1_q;
    assign hour0      = disp_h0_q;
    assign pm         = pm_q;
    assign set_ack    = ack_q;
    assign set_err    = err_q;
    assign sec_tick   = stick_q;
    assign day_tick   = dtick_q;
    assign alarm_hit  = hit_q;
    assign alarm_flag = flag_q;

endmodule
